fifo_burst_reader: RTL and testbench

Consumer-side controller for the 8-deep synchronous byte FIFO. On a start command it pops exactly `burst_len` bytes through the FIFO read port (`rd_en` / `empty` / `buf_out`) and re-issues them on a valid/ready output stream, tagging the final byte with `m_last`. It sits between the FIFO's read side and any downstream sink, such as a UART TX or a packet assembler. A 2-entry output buffer with in-flight read accounting sustains one byte per clock while respecting sink backpressure.

---
 rtl/fifo_burst_reader.sv | 99 +++++++++
 tb/tb_fifo_burst_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader for the 8-deep byte FIFO: pops burst_len bytes and replays them on a
// valid/ready stream through a 2-entry skid buffer, flagging the final byte with m_last.
module fifo_burst_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  // Output stream: a byte moves on every rising edge with m_valid=1 and m_ready=1;
  // m_data/m_valid never change while m_valid=1 and m_ready=0.
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  out_left;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic [1:0]        count;
  logic              inflight;

  logic              pop;
  logic [2:0]        occ_next;
  logic [1:0]        count_next;
  logic [DATA_W-1:0] buf0_next;
  logic [DATA_W-1:0] buf1_next;

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = buf0;
  assign m_last  = m_valid && (out_left == LEN_W'(1));
  assign busy    = (state == RUN);

  // Occupancy after this edge's pop, counting the byte still on its way from the FIFO.
  assign occ_next   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (issue_left != '0) && (occ_next < 3'd2);

  always_comb begin
    count_next = count + {1'b0, inflight} - {1'b0, pop};
    buf0_next  = pop ? buf1 : buf0;
    buf1_next  = buf1;
    if (inflight) begin
      // Tail slot is the first free one after the head has shifted out.
      if ((count - {1'b0, pop}) == 2'd0) buf0_next = fifo_data;
      else                               buf1_next = fifo_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_left <= '0;
      out_left   <= '0;
      buf0       <= '0;
      buf1       <= '0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_rd_en;
      count    <= count_next;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
      if (fifo_rd_en) issue_left <= issue_left - LEN_W'(1);
      if (pop && (out_left != '0)) out_left <= out_left - LEN_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            issue_left <= burst_len;
            out_left   <= burst_len;
            if (burst_len == '0) done  <= 1'b1;
            else                 state <= RUN;
          end
        end
        RUN: begin
          if (pop && (out_left == LEN_W'(1))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 8-deep FIFO on its read side
// and a scoreboard of hand-computed output bytes.
module tb_fifo_burst_reader;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic              done;

  fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // behavioural FIFO: buf_out registered on an accepted read
  logic [DATA_W-1:0] fifo_q[$];
  int push_total = 0;
  int pop_total  = 0;
  int rd_cnt     = 0;
  assign fifo_empty = (push_total == pop_total);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_q.pop_front();
      pop_total <= pop_total + 1;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic push_byte(input logic [DATA_W-1:0] b);
    fifo_q.push_back(b);
    push_total++;
  endtask

  task automatic fifo_clear();
    fifo_q.delete();
    push_total = pop_total;
  endtask

  function automatic int fifo_level();
    return push_total - pop_total;
  endfunction

  // bytes read from the FIFO but not yet handed to the sink
  int out_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) out_cnt <= 0;
    else     out_cnt <= out_cnt + ((fifo_rd_en && !fifo_empty) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
  end

  // scoreboard
  logic [DATA_W:0] exp_q[$];
  int hs_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic expect_byte(input logic [DATA_W-1:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("rden_when_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (fifo_rd_en) check("occ_limit", 32'((out_cnt - ((m_valid && m_ready) ? 1 : 0)) < 2), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("xfer_last_data", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
        hs_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int rd_base;
  int hs_base;

  initial begin
    // reset
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // basic burst: 10, 20, 30
    push_byte(8'd10); push_byte(8'd20); push_byte(8'd30);
    expect_byte(8'd10, 1'b0); expect_byte(8'd20, 1'b0); expect_byte(8'd30, 1'b1);
    m_ready = 1'b1;
    start_burst(8'd3);
    check("basic_busy_e0", 32'(busy), 32'd1);
    check("basic_valid_e0", 32'(m_valid), 32'd0);
    check("basic_rden_e0", 32'(fifo_rd_en), 32'd1);
    tick();
    check("basic_valid_e1", 32'(m_valid), 32'd0);
    tick();
    check("basic_valid_e2", 32'(m_valid), 32'd1);
    check("basic_data_e2", 32'(m_data), 32'd10);
    tick();
    check("basic_data_e3", 32'(m_data), 32'd20);
    tick();
    check("basic_data_e4", 32'(m_data), 32'd30);
    check("basic_last_e4", 32'(m_last), 32'd1);
    tick();
    check("basic_done_e5", 32'(done), 32'd1);
    check("basic_busy_e5", 32'(busy), 32'd0);
    check("basic_fifo_empty", 32'(fifo_level()), 32'd0);
    tick();
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_sb_drain", 32'(exp_q.size()), 32'd0);

    // backpressure: 1..8, stall first then random ready
    fifo_clear();
    for (int i = 1; i <= 8; i++) begin
      push_byte(8'(i));
      expect_byte(8'(i), i == 8);
    end
    m_ready = 1'b0;
    rd_base = rd_cnt;
    start_burst(8'd8);
    repeat (5) tick();
    check("bp_stall_reads", 32'(rd_cnt - rd_base), 32'd2);
    check("bp_stall_valid", 32'(m_valid), 32'd1);
    check("bp_stall_data", 32'(m_data), 32'd1);
    for (int n = 0; n < 200 && !done; n++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("bp_done", 32'(done), 32'd1);
    check("bp_sb_drain", 32'(exp_q.size()), 32'd0);
    check("bp_fifo_empty", 32'(fifo_level()), 32'd0);
    m_ready = 1'b1;
    tick();

    // underrun: 40 now, 50 at cycle 6, 60 at cycle 12
    fifo_clear();
    push_byte(8'd40);
    expect_byte(8'd40, 1'b0); expect_byte(8'd50, 1'b0); expect_byte(8'd60, 1'b1);
    hs_base = hs_cnt;
    start_burst(8'd3);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      tick();
      if (cyc == 6) push_byte(8'd50);
      if (cyc == 11) begin
        check("ur_busy_held", 32'(busy), 32'd1);
        check("ur_xfers_so_far", 32'(hs_cnt - hs_base), 32'd2);
      end
      if (cyc == 12) push_byte(8'd60);
    end
    check("ur_done", 32'(done), 32'd1);
    check("ur_sb_drain", 32'(exp_q.size()), 32'd0);
    tick();

    // zero length
    fifo_clear();
    push_byte(8'd99);
    rd_base = rd_cnt;
    start_burst(8'd0);
    check("zl_done", 32'(done), 32'd1);
    check("zl_busy", 32'(busy), 32'd0);
    check("zl_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    check("zl_done_pulse", 32'(done), 32'd0);
    check("zl_busy_after", 32'(busy), 32'd0);
    check("zl_no_reads", 32'(rd_cnt - rd_base), 32'd0);
    check("zl_fifo_level", 32'(fifo_level()), 32'd1);

    // start while busy: second start (len 5) ignored
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    expect_byte(8'd99, 1'b0); expect_byte(8'd1, 1'b0); expect_byte(8'd2, 1'b1);
    start_burst(8'd3);
    tick();
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0;
    wait_done("sb", 30);
    check("sb_reads", 32'(rd_cnt - rd_base), 32'd3);
    repeat (6) tick();
    check("sb_idle_after", 32'(busy), 32'd0);
    check("sb_fifo_level", 32'(fifo_level()), 32'd2);
    check("sb_sb_drain", 32'(exp_q.size()), 32'd0);

    // excess data: 5 bytes queued, burst of 2
    fifo_clear();
    for (int i = 11; i <= 15; i++) push_byte(8'(i));
    expect_byte(8'd11, 1'b0); expect_byte(8'd12, 1'b1);
    rd_base = rd_cnt;
    start_burst(8'd2);
    wait_done("ex", 30);
    repeat (3) tick();
    check("ex_reads", 32'(rd_cnt - rd_base), 32'd2);
    check("ex_fifo_level", 32'(fifo_level()), 32'd3);
    check("ex_sb_drain", 32'(exp_q.size()), 32'd0);

    // reset mid-burst after the third handshake
    fifo_clear();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    expect_byte(8'd1, 1'b0); expect_byte(8'd2, 1'b0); expect_byte(8'd3, 1'b0);
    hs_base = hs_cnt;
    start_burst(8'd8);
    for (int n = 0; n < 50 && (hs_cnt - hs_base) < 3; n++) tick();
    check("mr_three_xfers", 32'(hs_cnt - hs_base), 32'd3);
    rst = 1'b1;
    #1;
    check("mr_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mr_m_valid", 32'(m_valid), 32'd0);
    check("mr_m_data", 32'(m_data), 32'd0);
    check("mr_m_last", 32'(m_last), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    tick();
    check("mr_done_in_rst", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("mr_no_done", 32'(done), 32'd0);
    check("mr_fifo_level", 32'(fifo_level()), 32'd3);
    check("mr_sb_drain", 32'(exp_q.size()), 32'd0);
    expect_byte(8'd6, 1'b0); expect_byte(8'd7, 1'b1);
    start_burst(8'd2);
    wait_done("mr2", 30);
    check("mr2_fifo_level", 32'(fifo_level()), 32'd1);
    check("mr2_sb_drain", 32'(exp_q.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
